// File: rtl/rotary_quad_decoder_pkg.sv
// Shared definitions for the rotary encoder decoder: parameter defaults and direction encodings.
// Optional position counter is enabled by defining ROTARY_POS_EN.
package rotary_quad_decoder_pkg;

  localparam int DEB_CYCLES_DEF = 5000;
  localparam int DEB_W_DEF      = 13;
  localparam int POS_W_DEF      = 8;

  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

endpackage

// File: rtl/rotary_quad_decoder_rot_filter.sv
// One encoder channel: two-flop synchronizer followed by a restart-on-glitch debounce counter.
module rot_filter
  import rotary_quad_decoder_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             filt_reg;
  logic [DEB_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else if (cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/rotary_quad_decoder.sv
// Quadrature encoder decoder: debounced A/B -> one-cycle step pulse plus held direction.
// Define ROTARY_POS_EN to add the signed rotary_pos step counter.
module rotary_quad_decoder
  import rotary_quad_decoder_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
`ifdef ROTARY_POS_EN
  ,
  parameter int POS_W      = POS_W_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic rotary_a,
  input  logic rotary_b,
  output logic rotary_event,
  output logic rotary_left
`ifdef ROTARY_POS_EN
  ,
  output logic signed [POS_W-1:0] rotary_pos
`endif
);

  // Filters read 00 straight out of reset; arming waits until they can reflect the pins,
  // so an encoder resting at 11 through reset never looks like a fresh 00.
  localparam logic [DEB_W:0] WARM_LAST = (DEB_W + 1)'(DEB_CYCLES + 3);

  logic fa;
  logic fb;
  logic q1_reg;
  logic q2_reg;
  logic q1_d_reg;
  logic q2_d_reg;
  logic armed_reg;
  logic event_reg;
  logic left_reg;
  logic [DEB_W:0] warm_cnt_reg;
  logic warm_done;
  logic step_hit;

  rot_filter #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (rotary_a),
    .filt  (fa)
  );

  rot_filter #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (rotary_b),
    .filt  (fb)
  );

  assign warm_done = (warm_cnt_reg == WARM_LAST);
  assign step_hit  = q1_reg & ~q1_d_reg & armed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_reg       <= 1'b0;
      q2_reg       <= 1'b0;
      q1_d_reg     <= 1'b0;
      q2_d_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      event_reg    <= 1'b0;
      left_reg     <= 1'b0;
      warm_cnt_reg <= '0;
    end else begin
      if (fa & fb)
        q1_reg <= 1'b1;
      else if (~fa & ~fb)
        q1_reg <= 1'b0;
      // q2 remembers which channel led into the half-step
      if (~fa & fb)
        q2_reg <= 1'b1;
      else if (fa & ~fb)
        q2_reg <= 1'b0;
      q1_d_reg <= q1_reg;
      q2_d_reg <= q2_reg;
      if (!warm_done)
        warm_cnt_reg <= warm_cnt_reg + 1'b1;
      if (warm_done & ~fa & ~fb)
        armed_reg <= 1'b1;
      event_reg <= step_hit;
      if (step_hit)
        left_reg <= q2_d_reg ? ROT_LEFT : ROT_RIGHT;
    end
  end

  assign rotary_event = event_reg;
  assign rotary_left  = left_reg;

`ifdef ROTARY_POS_EN
  logic signed [POS_W-1:0] pos_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pos_reg <= '0;
    else if (step_hit)
      pos_reg <= (q2_d_reg == ROT_LEFT) ? pos_reg - POS_W'(1) : pos_reg + POS_W'(1);
  end

  assign rotary_pos = pos_reg;
`endif

endmodule
